// File: rtl/hex_print_sched_if.sv
// Bundle of requester, converter and byte-stream signals around hex_print_sched.
interface hex_print_sched_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned HEX_DIGITS = 2
);
    localparam int unsigned W = HEX_DIGITS * 4;

    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ-1:0]   req_eol_i;
    logic [NUM_REQ*W-1:0] req_data_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic                 cvt_den_o;
    logic [W-1:0]         cvt_data_o;
    logic                 cvt_busy_i;
    logic                 cvt_ascii_den_i;
    logic [7:0]           cvt_ascii_data_i;
    logic                 tx_room_i;
    logic                 tx_den_o;
    logic [7:0]           tx_data_o;
    logic                 busy_o;

    modport slave (
        input  req_i, req_eol_i, req_data_i, cvt_busy_i, cvt_ascii_den_i,
               cvt_ascii_data_i, tx_room_i,
        output gnt_o, cvt_den_o, cvt_data_o, tx_den_o, tx_data_o, busy_o
    );

    modport master (
        output req_i, req_eol_i, req_data_i, cvt_busy_i, cvt_ascii_den_i,
               cvt_ascii_data_i, tx_room_i,
        input  gnt_o, cvt_den_o, cvt_data_o, tx_den_o, tx_data_o, busy_o
    );
endinterface

// File: rtl/hex_print_sched.sv
// Round-robin scheduler sharing one hex2ascii converter between NUM_REQ requesters,
// streaming the digits followed by a separator or CR LF.
module hex_print_sched #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned HEX_DIGITS = 2,
    parameter logic [7:0]  SEP_CHAR   = 8'h20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    hex_print_sched_if.slave  bus
);
    localparam int unsigned W       = HEX_DIGITS * 4;
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0]  WD_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_RUN, S_DRAIN, S_SEP, S_LF, S_GAP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [W-1:0]       r_data, w_data_nxt;
    logic               r_eol, w_eol_nxt;
    logic [2:0]         r_wd, w_wd_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic               r_cvt_den, w_cvt_den_nxt;
    logic               r_tx_den, w_tx_den_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W-1:0]   w_cand;
    int unsigned        w_idx;

    // Round-robin pick: scan from highest offset down so the nearest requester wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            w_idx = 32'(r_ptr) + 32'(i);
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            w_cand = PTR_W'(w_idx);
            if (bus.req_i[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_data_nxt    = r_data;
        w_eol_nxt     = r_eol;
        w_wd_nxt      = r_wd;
        w_gnt_nxt     = '0;
        w_cvt_den_nxt = r_cvt_den;
        w_tx_den_nxt  = 1'b0;
        w_tx_data_nxt = r_tx_data;
        case (r_state)
            S_IDLE: begin
                if (w_found && bus.tx_room_i) begin
                    w_gnt_nxt     = NUM_REQ'(1) << w_sel;
                    w_data_nxt    = bus.req_data_i[32'(w_sel)*W +: W];
                    w_eol_nxt     = bus.req_eol_i[w_sel];
                    w_ptr_nxt     = (32'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + PTR_W'(1);
                    w_wd_nxt      = '0;
                    w_cvt_den_nxt = 1'b1;
                    w_state_nxt   = S_TRIG;
                end
            end
            S_TRIG: begin
                if (bus.cvt_busy_i) begin
                    w_cvt_den_nxt = 1'b0;
                    w_state_nxt   = S_RUN;
                end else if (r_wd == WD_LAST) begin
                    // converter never started: abandon this value
                    w_cvt_den_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_wd_nxt = r_wd + 3'd1;
                end
            end
            S_RUN: begin
                w_tx_den_nxt  = bus.cvt_ascii_den_i;
                w_tx_data_nxt = bus.cvt_ascii_data_i;
                if (!bus.cvt_busy_i) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_tx_den_nxt  = bus.cvt_ascii_den_i;
                w_tx_data_nxt = bus.cvt_ascii_data_i;
                w_state_nxt   = S_SEP;
            end
            S_SEP: begin
                w_tx_den_nxt  = 1'b1;
                w_tx_data_nxt = r_eol ? 8'h0D : SEP_CHAR;
                w_state_nxt   = r_eol ? S_LF : S_GAP;
            end
            S_LF: begin
                w_tx_den_nxt  = 1'b1;
                w_tx_data_nxt = 8'h0A;
                w_state_nxt   = S_GAP;
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_data    <= '0;
            r_eol     <= 1'b0;
            r_wd      <= '0;
            r_gnt     <= '0;
            r_cvt_den <= 1'b0;
            r_tx_den  <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_data    <= w_data_nxt;
            r_eol     <= w_eol_nxt;
            r_wd      <= w_wd_nxt;
            r_gnt     <= w_gnt_nxt;
            r_cvt_den <= w_cvt_den_nxt;
            r_tx_den  <= w_tx_den_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.gnt_o      = r_gnt;
    assign bus.cvt_den_o  = r_cvt_den;
    assign bus.cvt_data_o = r_data;
    assign bus.tx_den_o   = r_tx_den;
    assign bus.tx_data_o  = r_tx_data;
    assign bus.busy_o     = r_busy;
endmodule

// File: tb/tb_hex_print_sched.sv
// Directed bench for hex_print_sched: 2-digit and 4-digit instances, each with a converter model.
module tb_hex_print_sched;
    logic clk;
    logic rst_n;
    logic no_busy;
    int   tests;
    int   fails;
    int   cyc;

    hex_print_sched_if #(.NUM_REQ(2), .HEX_DIGITS(2)) ifa ();
    hex_print_sched_if #(.NUM_REQ(2), .HEX_DIGITS(4)) ifb ();

    hex_print_sched #(.NUM_REQ(2), .HEX_DIGITS(2), .SEP_CHAR(8'h20)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    hex_print_sched #(.NUM_REQ(2), .HEX_DIGITS(4), .SEP_CHAR(8'h20)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    always #5 clk = ~clk;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    // Converter model: edge-detected start, busy 2 clk after den, chars lag busy by 1 clk.
    logic a_den_q;
    int   a_p, a_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_den_q <= 1'b0; a_p <= 0; a_idx <= 0;
            ifa.cvt_busy_i <= 1'b0; ifa.cvt_ascii_den_i <= 1'b0; ifa.cvt_ascii_data_i <= 8'h00;
        end else begin
            a_den_q <= ifa.cvt_den_o;
            case (a_p)
                0: begin
                    ifa.cvt_ascii_den_i <= 1'b0;
                    if (ifa.cvt_den_o && !a_den_q && !no_busy) a_p <= 1;
                end
                1: begin ifa.cvt_busy_i <= 1'b1; a_idx <= 0; a_p <= 2; end
                default: begin
                    ifa.cvt_ascii_den_i  <= 1'b1;
                    ifa.cvt_ascii_data_i <= hex_char(4'(ifa.cvt_data_o >> (4 * (1 - a_idx))));
                    a_idx <= a_idx + 1;
                    if (a_idx == 1) begin ifa.cvt_busy_i <= 1'b0; a_p <= 0; end
                end
            endcase
        end
    end

    logic b_den_q;
    int   b_p, b_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_den_q <= 1'b0; b_p <= 0; b_idx <= 0;
            ifb.cvt_busy_i <= 1'b0; ifb.cvt_ascii_den_i <= 1'b0; ifb.cvt_ascii_data_i <= 8'h00;
        end else begin
            b_den_q <= ifb.cvt_den_o;
            case (b_p)
                0: begin
                    ifb.cvt_ascii_den_i <= 1'b0;
                    if (ifb.cvt_den_o && !b_den_q && !no_busy) b_p <= 1;
                end
                1: begin ifb.cvt_busy_i <= 1'b1; b_idx <= 0; b_p <= 2; end
                default: begin
                    ifb.cvt_ascii_den_i  <= 1'b1;
                    ifb.cvt_ascii_data_i <= hex_char(4'(ifb.cvt_data_o >> (4 * (3 - b_idx))));
                    b_idx <= b_idx + 1;
                    if (b_idx == 3) begin ifb.cvt_busy_i <= 1'b0; b_p <= 0; end
                end
            endcase
        end
    end

    // Output monitors, sampled on the falling edge.
    logic [7:0] a_bytes[$], b_bytes[$];
    logic [1:0] a_gnt[$], b_gnt[$];
    int         a_gnt_cyc[$], b_gnt_cyc[$];
    int         a_den_cnt;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ifa.tx_den_o) a_bytes.push_back(ifa.tx_data_o);
        if (ifb.tx_den_o) b_bytes.push_back(ifb.tx_data_o);
        if (|ifa.gnt_o) begin a_gnt.push_back(ifa.gnt_o); a_gnt_cyc.push_back(cyc); end
        if (|ifb.gnt_o) begin b_gnt.push_back(ifb.gnt_o); b_gnt_cyc.push_back(cyc); end
        if (ifa.cvt_den_o) a_den_cnt <= a_den_cnt + 1;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifa.req_i = '0; ifa.req_eol_i = '0; ifa.req_data_i = '0; ifa.tx_room_i = 1'b1;
        ifb.req_i = '0; ifb.req_eol_i = '0; ifb.req_data_i = '0; ifb.tx_room_i = 1'b1;
        no_busy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        a_bytes.delete(); b_bytes.delete(); a_gnt.delete(); b_gnt.delete();
        a_gnt_cyc.delete(); b_gnt_cyc.delete(); a_den_cnt = 0;
    endtask

    task automatic wait_a_gnt(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_gnt.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_b_gnt(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b_gnt.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_a_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!ifa.busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_b_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!ifb.busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.req_i = 2'b11; ifb.req_i = 2'b11;
        tick(); tick();
        tests++; if ({ifa.gnt_o, ifa.cvt_den_o, ifa.tx_den_o, ifa.busy_o} !== 5'b0) begin
            fails++; $display("FAIL reset_a_ctrl: got %b expected 00000", {ifa.gnt_o, ifa.cvt_den_o, ifa.tx_den_o, ifa.busy_o}); end
        tests++; if ({ifa.cvt_data_o, ifa.tx_data_o} !== 16'h0) begin
            fails++; $display("FAIL reset_a_data: got %h expected 0000", {ifa.cvt_data_o, ifa.tx_data_o}); end
        tests++; if ({ifb.gnt_o, ifb.cvt_den_o, ifb.tx_den_o, ifb.busy_o, ifb.cvt_data_o} !== 21'h0) begin
            fails++; $display("FAIL reset_b: got %h expected 0", {ifb.gnt_o, ifb.cvt_den_o, ifb.tx_den_o, ifb.busy_o, ifb.cvt_data_o}); end
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] exp[$];
        bit ok;
        exp = '{8'h41, 8'h33, 8'h20};
        do_reset();
        ifa.req_data_i = {8'h00, 8'hA3}; ifa.req_i = 2'b01;
        wait_a_gnt(1, ok);
        ifa.req_i = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL single_gnt_timeout: got no grant expected grant"); end
        tests++; if (ifa.cvt_data_o !== 8'hA3) begin
            fails++; $display("FAIL single_cvt_data: got %h expected a3", ifa.cvt_data_o); end
        wait_a_idle(ok);
        repeat (3) tick();
        tests++; if (!ok || ifa.busy_o !== 1'b0) begin fails++; $display("FAIL single_busy: got %b expected 0", ifa.busy_o); end
        tests++; if (a_gnt.size() != 1 || a_gnt[0] !== 2'b01) begin
            fails++; $display("FAIL single_gnt: got %0d grants first %b expected 1 grant 01", a_gnt.size(), a_gnt[0]); end
        tests++; if (a_bytes.size() != exp.size()) begin
            fails++; $display("FAIL single_len: got %0d expected %0d", a_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < a_bytes.size(); i++) begin
            tests++; if (a_bytes[i] !== exp[i]) begin
                fails++; $display("FAIL single_byte%0d: got %h expected %h", i, a_bytes[i], exp[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp[$];
        bit ok;
        exp = '{8'h31, 8'h46, 8'h20, 8'h43, 8'h30, 8'h0D, 8'h0A, 8'h31, 8'h46, 8'h20};
        do_reset();
        ifa.req_data_i = {8'hC0, 8'h1F}; ifa.req_eol_i = 2'b10; ifa.req_i = 2'b11;
        wait_a_gnt(3, ok);
        ifa.req_i = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL rr_gnt_timeout: got %0d grants expected 3", a_gnt.size()); end
        wait_a_idle(ok);
        repeat (3) tick();
        tests++; if (a_gnt.size() != 3 || a_gnt[0] !== 2'b01 || a_gnt[1] !== 2'b10 || a_gnt[2] !== 2'b01) begin
            fails++; $display("FAIL rr_order: got %0d grants %b %b %b expected 01 10 01", a_gnt.size(), a_gnt[0], a_gnt[1], a_gnt[2]); end
        tests++; if (a_gnt_cyc.size() == 3 && ((a_gnt_cyc[1] - a_gnt_cyc[0]) < 8 || (a_gnt_cyc[2] - a_gnt_cyc[1]) < 9)) begin
            fails++; $display("FAIL rr_spacing: got %0d %0d expected >=8 >=9", a_gnt_cyc[1] - a_gnt_cyc[0], a_gnt_cyc[2] - a_gnt_cyc[1]); end
        tests++; if (a_bytes.size() != exp.size()) begin
            fails++; $display("FAIL rr_len: got %0d expected %0d", a_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < a_bytes.size(); i++) begin
            tests++; if (a_bytes[i] !== exp[i]) begin
                fails++; $display("FAIL rr_byte%0d: got %h expected %h", i, a_bytes[i], exp[i]); end
        end
    endtask

    task automatic test_no_room();
        logic [7:0] exp[$];
        bit ok;
        exp = '{8'h35, 8'h43, 8'h20};
        do_reset();
        ifa.tx_room_i = 1'b0; ifa.req_data_i = {8'h00, 8'h5C}; ifa.req_i = 2'b01;
        repeat (20) tick();
        tests++; if (a_gnt.size() != 0 || a_bytes.size() != 0 || ifa.busy_o !== 1'b0) begin
            fails++; $display("FAIL noroom_stall: got %0d grants %0d bytes busy %b expected 0 0 0", a_gnt.size(), a_bytes.size(), ifa.busy_o); end
        ifa.tx_room_i = 1'b1;
        wait_a_gnt(1, ok);
        ifa.req_i = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL noroom_gnt_timeout: got no grant expected grant"); end
        wait_a_idle(ok);
        repeat (3) tick();
        tests++; if (a_bytes.size() != exp.size()) begin
            fails++; $display("FAIL noroom_len: got %0d expected %0d", a_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < a_bytes.size(); i++) begin
            tests++; if (a_bytes[i] !== exp[i]) begin
                fails++; $display("FAIL noroom_byte%0d: got %h expected %h", i, a_bytes[i], exp[i]); end
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        do_reset();
        no_busy = 1'b1;
        ifa.req_data_i = {8'h00, 8'h77}; ifa.req_i = 2'b01;
        wait_a_gnt(1, ok);
        ifa.req_i = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL wd_gnt_timeout: got no grant expected grant"); end
        wait_a_idle(ok);
        repeat (3) tick();
        tests++; if (a_den_cnt != 8) begin fails++; $display("FAIL wd_den_cycles: got %0d expected 8", a_den_cnt); end
        tests++; if (!ok || ifa.busy_o !== 1'b0 || ifa.cvt_den_o !== 1'b0) begin
            fails++; $display("FAIL wd_idle: got busy %b den %b expected 0 0", ifa.busy_o, ifa.cvt_den_o); end
        tests++; if (a_bytes.size() != 0) begin fails++; $display("FAIL wd_bytes: got %0d expected 0", a_bytes.size()); end
        no_busy = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        logic [7:0] exp[$];
        bit ok;
        exp = '{8'h39, 8'h42, 8'h20};
        do_reset();
        ifa.req_data_i = {8'h00, 8'h6E}; ifa.req_i = 2'b01;
        wait_a_gnt(1, ok);
        ifa.req_i = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a_bytes.size() >= 1) begin ok = 1'b1; break; end
            tick();
        end
        tests++; if (!ok) begin fails++; $display("FAIL midrst_first_char: got none expected one char"); end
        rst_n = 1'b0;
        #1;
        tests++; if ({ifa.gnt_o, ifa.cvt_den_o, ifa.tx_den_o, ifa.busy_o, ifa.tx_data_o, ifa.cvt_data_o} !== 21'h0) begin
            fails++; $display("FAIL midrst_outputs: got %h expected 0", {ifa.gnt_o, ifa.cvt_den_o, ifa.tx_den_o, ifa.busy_o, ifa.tx_data_o, ifa.cvt_data_o}); end
        tick();
        rst_n = 1'b1;
        a_bytes.delete(); a_gnt.delete();
        repeat (6) tick();
        tests++; if (a_bytes.size() != 0) begin fails++; $display("FAIL midrst_trailing: got %0d bytes expected 0", a_bytes.size()); end
        ifa.req_data_i = {8'h00, 8'h9B}; ifa.req_i = 2'b01;
        wait_a_gnt(1, ok);
        ifa.req_i = 2'b00;
        wait_a_idle(ok);
        repeat (3) tick();
        tests++; if (a_bytes.size() != exp.size()) begin
            fails++; $display("FAIL midrst_len: got %0d expected %0d", a_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < a_bytes.size(); i++) begin
            tests++; if (a_bytes[i] !== exp[i]) begin
                fails++; $display("FAIL midrst_byte%0d: got %h expected %h", i, a_bytes[i], exp[i]); end
        end
    endtask

    task automatic test_wide();
        logic [7:0] exp[$];
        bit ok;
        exp = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h20, 8'h31, 8'h32, 8'h33, 8'h34, 8'h20};
        do_reset();
        ifb.req_data_i = {16'h1234, 16'hBEEF}; ifb.req_i = 2'b11;
        wait_b_gnt(2, ok);
        ifb.req_i = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL wide_gnt_timeout: got %0d grants expected 2", b_gnt.size()); end
        wait_b_idle(ok);
        repeat (3) tick();
        tests++; if (b_gnt.size() != 2 || b_gnt[0] !== 2'b01 || b_gnt[1] !== 2'b10) begin
            fails++; $display("FAIL wide_order: got %0d grants %b %b expected 01 10", b_gnt.size(), b_gnt[0], b_gnt[1]); end
        tests++; if (b_gnt_cyc.size() == 2 && (b_gnt_cyc[1] - b_gnt_cyc[0]) < 10) begin
            fails++; $display("FAIL wide_spacing: got %0d expected >=10", b_gnt_cyc[1] - b_gnt_cyc[0]); end
        tests++; if (b_bytes.size() != exp.size()) begin
            fails++; $display("FAIL wide_len: got %0d expected %0d", b_bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < b_bytes.size(); i++) begin
            tests++; if (b_bytes[i] !== exp[i]) begin
                fails++; $display("FAIL wide_byte%0d: got %h expected %h", i, b_bytes[i], exp[i]); end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; no_busy = 1'b0; tests = 0; fails = 0; cyc = 0; a_den_cnt = 0;
        ifa.req_i = '0; ifa.req_eol_i = '0; ifa.req_data_i = '0; ifa.tx_room_i = 1'b1;
        ifb.req_i = '0; ifb.req_eol_i = '0; ifb.req_data_i = '0; ifb.tx_room_i = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_no_room();
        test_watchdog();
        test_reset_mid_job();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected summary");
        $fatal(1);
    end
endmodule
